// File: rtl/ifu_pkg.sv
// Shared constants and types for the instruction-fetch prefetch unit.
package ifu_pkg;

  localparam int INST_W  = 32;
  localparam int PC_STEP = 4;

  typedef enum logic [1:0] {
    IDLE,
    RUN,
    HALTED
  } fetch_state_t;

  // Width of a counter that must hold 0..depth inclusive.
  function automatic int cnt_w(input int depth);
    return $clog2(depth + 1);
  endfunction

endpackage

// File: rtl/ifu_fifo.sv
// Synchronous FIFO with flush and occupancy count.
// The head entry is read straight from storage flops, so a push is visible
// at dout_o on the following cycle. A push into a full FIFO is accepted
// when a pop happens in the same cycle.
module ifu_fifo #(
  parameter type T        = logic [31:0],
  parameter int  DEPTH    = 4,
  localparam int AW       = $clog2(DEPTH),
  localparam int CW       = $clog2(DEPTH + 1)
) (
  input  logic          clk,
  input  logic          rst_n,
  input  logic          flush_i,
  input  logic          push_i,
  input  T              din_i,
  input  logic          pop_i,
  output T              dout_o,
  output logic          empty_o,
  output logic          full_o,
  output logic [CW-1:0] count_o
);

  T              mem_q [DEPTH];
  T              mem_d [DEPTH];
  logic [AW-1:0] wr_ptr_q, wr_ptr_d;
  logic [AW-1:0] rd_ptr_q, rd_ptr_d;
  logic [CW-1:0] count_q, count_d;
  logic          do_push, do_pop;

  assign empty_o = (count_q == '0);
  assign full_o  = (count_q == CW'(DEPTH));
  assign count_o = count_q;
  assign dout_o  = mem_q[rd_ptr_q];
  assign do_pop  = pop_i & ~empty_o;
  assign do_push = push_i & (~full_o | do_pop);

  // Next-state: flush wins over push/pop; otherwise update pointers and count.
  always_comb begin
    mem_d    = mem_q;
    wr_ptr_d = wr_ptr_q;
    rd_ptr_d = rd_ptr_q;
    count_d  = count_q;
    if (flush_i) begin
      wr_ptr_d = '0;
      rd_ptr_d = '0;
      count_d  = '0;
    end else begin
      if (do_push) begin
        mem_d[wr_ptr_q] = din_i;
        wr_ptr_d        = wr_ptr_q + AW'(1);
      end
      if (do_pop) rd_ptr_d = rd_ptr_q + AW'(1);
      count_d = count_q + CW'(do_push) - CW'(do_pop);
    end
  end

  // Storage and pointer registers; storage is cleared so the head reads 0 out of reset.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      for (int i = 0; i < DEPTH; i++) mem_q[i] <= '0;
      wr_ptr_q <= '0;
      rd_ptr_q <= '0;
      count_q  <= '0;
    end else begin
      mem_q    <= mem_d;
      wr_ptr_q <= wr_ptr_d;
      rd_ptr_q <= rd_ptr_d;
      count_q  <= count_d;
    end
  end

endmodule

// File: rtl/ifu_prefetch.sv
// Instruction prefetch unit: owns the PC, issues in-order imem fetches under
// a credit limit, buffers responses in a FIFO and hands {inst, pc} to decode.
// Supports redirect (flush + restart) and halt.
module ifu_prefetch
  import ifu_pkg::*;
#(
  parameter int              XLEN     = 32,
  parameter int              DEPTH    = 4,
  parameter logic [XLEN-1:0] RESET_PC = '0
) (
  input  logic              clk,
  input  logic              rst_n,
  input  logic              halt_i,
  input  logic              redirect_valid_i,
  input  logic [XLEN-1:0]   redirect_pc_i,
  output logic              imem_req_valid_o,
  input  logic              imem_req_ready_i,
  output logic [XLEN-1:0]   imem_req_addr_o,
  input  logic              imem_rsp_valid_i,
  input  logic [INST_W-1:0] imem_rsp_data_i,
  output logic              inst_valid_o,
  input  logic              inst_ready_i,
  output logic [INST_W-1:0] inst_o,
  output logic [XLEN-1:0]   inst_pc_o
);

  localparam int CW = cnt_w(DEPTH);

  typedef struct packed {
    logic [INST_W-1:0] inst;
    logic [XLEN-1:0]   pc;
  } fetch_entry_t;

  fetch_state_t    state_q, state_d;
  logic [XLEN-1:0] fetch_pc_q, fetch_pc_d;
  logic [XLEN-1:0] rsp_pc_q, rsp_pc_d;
  logic [XLEN-1:0] req_addr_q, req_addr_d;
  logic [CW-1:0]   outstanding_q, outstanding_d;
  logic [CW-1:0]   discard_q, discard_d;
  // pending: request offered but not yet accepted; stale: that request predates a redirect
  logic            pending_q, pending_d;
  logic            stale_q, stale_d;

  logic            req_valid, accept, rsp_ok, push, pop, credit_ok;
  logic [XLEN-1:0] req_addr, redir_pc;
  logic [CW:0]     credit_used;
  logic [CW-1:0]   fifo_count;
  logic            fifo_empty, fifo_full;
  fetch_entry_t    fifo_head;
  logic            unused_pc_lsbs;

  assign redir_pc       = {redirect_pc_i[XLEN-1:2], 2'b00};
  assign unused_pc_lsbs = ^redirect_pc_i[1:0];
  assign credit_used    = {1'b0, fifo_count} + {1'b0, outstanding_q};
  assign credit_ok      = credit_used < (CW+1)'(DEPTH);

  // FSM next state, issue/credit logic and counter/PC bookkeeping.
  always_comb begin
    state_d       = state_q;
    fetch_pc_d    = fetch_pc_q;
    rsp_pc_d      = rsp_pc_q;
    outstanding_d = outstanding_q;
    discard_d     = discard_q;

    // A held request stays valid and stable regardless of halt or redirect.
    req_valid  = pending_q | ((state_q == RUN) & ~halt_i & credit_ok);
    req_addr   = pending_q ? req_addr_q : fetch_pc_q;
    accept     = req_valid & imem_req_ready_i;
    pending_d  = req_valid & ~imem_req_ready_i;
    req_addr_d = req_addr;
    stale_d    = pending_d & (redirect_valid_i | stale_q);

    // Responses with nothing outstanding are ignored (flagged by assertion).
    rsp_ok = imem_rsp_valid_i & (outstanding_q != '0);
    push   = rsp_ok & (discard_q == '0) & ~redirect_valid_i;
    pop    = ~fifo_empty & inst_ready_i;

    outstanding_d = outstanding_q + CW'(accept) - CW'(rsp_ok);

    if (redirect_valid_i) begin
      // Everything already issued, plus a held request, belongs to the old stream.
      discard_d  = outstanding_d + CW'(pending_d);
      fetch_pc_d = redir_pc;
      rsp_pc_d   = redir_pc;
    end else begin
      if (rsp_ok && discard_q != '0) discard_d = discard_q - CW'(1);
      // Accepting a held pre-redirect request must not advance the new PC.
      if (accept && !stale_q) fetch_pc_d = fetch_pc_q + XLEN'(PC_STEP);
      if (push) rsp_pc_d = rsp_pc_q + XLEN'(PC_STEP);
    end

    unique case (state_q)
      IDLE:    state_d = RUN;
      RUN:     if (halt_i && !pending_d) state_d = HALTED;
      HALTED:  if (!halt_i) state_d = RUN;
      default: state_d = IDLE;
    endcase
  end

  // State registers.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state_q       <= IDLE;
      fetch_pc_q    <= RESET_PC;
      rsp_pc_q      <= RESET_PC;
      req_addr_q    <= RESET_PC;
      outstanding_q <= '0;
      discard_q     <= '0;
      pending_q     <= 1'b0;
      stale_q       <= 1'b0;
    end else begin
      state_q       <= state_d;
      fetch_pc_q    <= fetch_pc_d;
      rsp_pc_q      <= rsp_pc_d;
      req_addr_q    <= req_addr_d;
      outstanding_q <= outstanding_d;
      discard_q     <= discard_d;
      pending_q     <= pending_d;
      stale_q       <= stale_d;
    end
  end

  ifu_fifo #(
    .T     (fetch_entry_t),
    .DEPTH (DEPTH)
  ) u_fifo (
    .clk     (clk),
    .rst_n   (rst_n),
    .flush_i (redirect_valid_i),
    .push_i  (push),
    .din_i   ('{inst: imem_rsp_data_i, pc: rsp_pc_q}),
    .pop_i   (pop),
    .dout_o  (fifo_head),
    .empty_o (fifo_empty),
    .full_o  (fifo_full),
    .count_o (fifo_count)
  );

  assign imem_req_valid_o = req_valid;
  assign imem_req_addr_o  = req_addr;
  assign inst_valid_o     = ~fifo_empty;
  assign inst_o           = fifo_head.inst;
  assign inst_pc_o        = fifo_head.pc;

  // Protocol checks: stray imem response, and FIFO overflow despite the credit limit.
  always @(posedge clk) begin
    if (rst_n) begin
      assert (!(imem_rsp_valid_i && outstanding_q == '0));
      assert (!(push && fifo_full && !pop));
    end
  end

endmodule

// File: tb/tb_ifu_prefetch.sv
// Directed bench for ifu_prefetch with a variable-latency imem responder.
module tb_ifu_prefetch;

  localparam logic [31:0] K = 32'h1357_9BDF;  // imem data = addr ^ K

  logic        clk = 1'b0;
  logic        rst_n;
  logic        halt, redir, req_ready, inst_ready;
  logic [31:0] redir_pc;
  logic        req_valid, rsp_valid, inst_valid;
  logic [31:0] req_addr, rsp_data, inst, inst_pc;

  // second instance: RESET_PC near the top of the address space, latency-1 imem
  logic        req2_valid, rsp2_valid, inst2_valid;
  logic [31:0] req2_addr, rsp2_data, inst2, inst2_pc;

  int checks = 0;
  int errors = 0;
  int lat    = 1;
  int cyc    = 0;

  always #5 clk = ~clk;

  ifu_prefetch #(.XLEN(32), .DEPTH(4), .RESET_PC(32'h0)) dut (
    .clk              (clk),
    .rst_n            (rst_n),
    .halt_i           (halt),
    .redirect_valid_i (redir),
    .redirect_pc_i    (redir_pc),
    .imem_req_valid_o (req_valid),
    .imem_req_ready_i (req_ready),
    .imem_req_addr_o  (req_addr),
    .imem_rsp_valid_i (rsp_valid),
    .imem_rsp_data_i  (rsp_data),
    .inst_valid_o     (inst_valid),
    .inst_ready_i     (inst_ready),
    .inst_o           (inst),
    .inst_pc_o        (inst_pc)
  );

  ifu_prefetch #(.XLEN(32), .DEPTH(4), .RESET_PC(32'hFFFF_FFF8)) dut2 (
    .clk              (clk),
    .rst_n            (rst_n),
    .halt_i           (1'b0),
    .redirect_valid_i (1'b0),
    .redirect_pc_i    (32'h0),
    .imem_req_valid_o (req2_valid),
    .imem_req_ready_i (1'b1),
    .imem_req_addr_o  (req2_addr),
    .imem_rsp_valid_i (rsp2_valid),
    .imem_rsp_data_i  (rsp2_data),
    .inst_valid_o     (inst2_valid),
    .inst_ready_i     (1'b1),
    .inst_o           (inst2),
    .inst_pc_o        (inst2_pc)
  );

  // imem model: accepted request at edge n is presented after edge n+lat-1, in order.
  typedef struct { logic [31:0] addr; int due; } rsp_t;
  rsp_t q[$];

  always @(posedge clk) begin
    if (!rst_n) begin
      q.delete();
      rsp_valid <= 1'b0;
      rsp_data  <= '0;
    end else begin
      if (rsp_valid) void'(q.pop_front());
      if (req_valid && req_ready) q.push_back('{req_addr, cyc + lat - 1});
      if (q.size() > 0 && q[0].due <= cyc) begin
        rsp_valid <= 1'b1;
        rsp_data  <= q[0].addr ^ K;
      end else begin
        rsp_valid <= 1'b0;
      end
    end
    cyc <= cyc + 1;
  end

  always @(posedge clk) begin
    if (!rst_n) begin
      rsp2_valid <= 1'b0;
      rsp2_data  <= '0;
    end else begin
      rsp2_valid <= req2_valid;
      rsp2_data  <= req2_addr ^ K;
    end
  end

  task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    checks++;
    assert (obs === exp) else begin
      errors++;
      $error("FAIL %s observed=%h expected=%h", tag, obs, exp);
    end
  endtask

  task automatic step();
    @(negedge clk);
  endtask

  task automatic do_reset(input int l);
    rst_n = 1'b0;
    lat   = l;
    repeat (3) @(negedge clk);
    rst_n = 1'b1;
  endtask

  initial begin
    int n;
    rst_n = 1'b0; halt = 1'b0; redir = 1'b0; redir_pc = '0;
    req_ready = 1'b1; inst_ready = 1'b1; lat = 1;
    repeat (3) step();

    // reset state
    chk("rst_req_valid", 32'(req_valid), 32'd0);
    chk("rst_req_addr", req_addr, 32'h0);
    chk("rst_inst_valid", 32'(inst_valid), 32'd0);
    chk("rst_inst", inst, 32'h0);
    chk("rst_inst_pc", inst_pc, 32'h0);
    chk("rst2_req_addr", req2_addr, 32'hFFFF_FFF8);

    // 1: latency 1, everything ready -> one instruction per cycle; dut2 wraps
    rst_n = 1'b1;
    step(); chk("t1_req_valid", 32'(req_valid), 32'd1); chk("t1_req_addr", req_addr, 32'h0);
    step(); chk("t1_empty", 32'(inst_valid), 32'd0);
    step(); chk("t1_pc0", inst_pc, 32'h0); chk("t1_inst0", inst, 32'h0 ^ K);
    chk("t1_valid", 32'(inst_valid), 32'd1); chk("t5_pc0", inst2_pc, 32'hFFFF_FFF8);
    step(); chk("t1_pc4", inst_pc, 32'h4); chk("t5_pc1", inst2_pc, 32'hFFFF_FFFC);
    chk("t5_inst1", inst2, 32'hFFFF_FFFC ^ K);
    step(); chk("t1_pc8", inst_pc, 32'h8); chk("t5_pc2", inst2_pc, 32'h0);
    chk("t5_valid2", 32'(inst2_valid), 32'd1);
    step(); chk("t1_pcc", inst_pc, 32'hC); chk("t1_instc", inst, 32'hC ^ K);

    // 2: latency 3, decode stalled -> credit limit of 4 requests
    inst_ready = 1'b0;
    do_reset(3);
    n = 0;
    for (int i = 0; i < 12; i++) begin
      step();
      if (req_valid && req_ready) n++;
    end
    chk("t2_accepts", 32'(n), 32'd4);
    chk("t2_req_idle", 32'(req_valid), 32'd0);
    chk("t2_pc0", inst_pc, 32'h0);
    inst_ready = 1'b1;
    step(); chk("t2_pc4", inst_pc, 32'h4); chk("t2_inst4", inst, 32'h4 ^ K);
    chk("t2_resume_v", 32'(req_valid), 32'd1); chk("t2_resume_a", req_addr, 32'h10);
    step(); chk("t2_pc8", inst_pc, 32'h8);
    step(); chk("t2_pcc", inst_pc, 32'hC);

    // 3: redirect with 3 requests in flight
    do_reset(3);
    repeat (3) step();
    redir = 1'b1; redir_pc = 32'h103;
    step();
    redir = 1'b0;
    chk("t3_req_valid", 32'(req_valid), 32'd1);
    chk("t3_req_addr", req_addr, 32'h100);
    chk("t3_flushed", 32'(inst_valid), 32'd0);
    n = 0;
    while (!inst_valid && n < 20) begin
      step();
      n++;
    end
    chk("t3_latency", 32'(n), 32'd4);
    chk("t3_pc100", inst_pc, 32'h100); chk("t3_inst100", inst, 32'h100 ^ K);
    step(); chk("t3_pc104", inst_pc, 32'h104);

    // 4: imem stall with a redirect while the request is held
    req_ready = 1'b0;
    do_reset(1);
    step(); chk("t4_hold_v", 32'(req_valid), 32'd1); chk("t4_hold_a0", req_addr, 32'h0);
    step();
    redir = 1'b1; redir_pc = 32'h200;
    step();
    redir = 1'b0;
    chk("t4_hold_v2", 32'(req_valid), 32'd1); chk("t4_hold_a1", req_addr, 32'h0);
    step(); step(); chk("t4_hold_a2", req_addr, 32'h0);
    req_ready = 1'b1;
    step(); chk("t4_new_addr", req_addr, 32'h200); chk("t4_new_v", 32'(req_valid), 32'd1);
    step(); chk("t4_dropped", 32'(inst_valid), 32'd0);
    step(); chk("t4_valid", 32'(inst_valid), 32'd1); chk("t4_pc200", inst_pc, 32'h200);

    // 6: halt with 2 in flight, then asynchronous reset mid-stream
    do_reset(3);
    repeat (3) step();
    halt = 1'b1;
    n = 0;
    step(); if (req_valid && req_ready) n++;
    chk("t6_no_req", 32'(req_valid), 32'd0);
    step(); if (req_valid && req_ready) n++;
    chk("t6_pc0", inst_pc, 32'h0); chk("t6_v0", 32'(inst_valid), 32'd1);
    step(); if (req_valid && req_ready) n++;
    chk("t6_pc4", inst_pc, 32'h4);
    step(); if (req_valid && req_ready) n++;
    chk("t6_drained", 32'(inst_valid), 32'd0);
    chk("t6_halt_accepts", 32'(n), 32'd0);
    halt = 1'b0;
    step(); chk("t6_resume_a", req_addr, 32'h8); chk("t6_resume_v", 32'(req_valid), 32'd1);
    repeat (4) step();
    chk("t6_pc8", inst_pc, 32'h8); chk("t6_v8", 32'(inst_valid), 32'd1);
    #1 rst_n = 1'b0;
    #1;
    chk("t6_arst_req_v", 32'(req_valid), 32'd0);
    chk("t6_arst_addr", req_addr, 32'h0);
    chk("t6_arst_inst_v", 32'(inst_valid), 32'd0);
    chk("t6_arst_inst", inst, 32'h0);
    chk("t6_arst_pc", inst_pc, 32'h0);
    repeat (2) step();
    rst_n = 1'b1;
    step(); chk("t6_restart_a", req_addr, 32'h0); chk("t6_restart_v", 32'(req_valid), 32'd1);
    repeat (4) step();
    chk("t6_restart_pc", inst_pc, 32'h0); chk("t6_restart_iv", 32'(inst_valid), 32'd1);

    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end

endmodule
